// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [2:0] {
      StRun,
      StMemWait,
      StDrain,
      StHalted,
      StError
   } hazState_e;

   // Encoding loaded into IF/ID when it is flushed (sll $0,$0,0).
   localparam logic [31:0] NopInstr = 32'h0000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, memory wait,
// halt/drain, memory timeout and event counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned MEM_TIMEOUT  = 64,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_load,
   input  logic [4:0]       ex_wreg,
   input  logic             id_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_bubble,
   output logic             exmm_en,
   output logic             mmwb_bubble,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   hazState_e         stateQ;
   logic [8:0]        waitCntQ;
   logic [DrainW-1:0] drainCntQ;
   logic              haltFlagQ;
   logic              errQ;
   logic              haltedQ;

   logic              memWait;
   logic              loadUse;
   logic              draining;
   logic              stallInc;
   logic              flushInc;
   logic [8:0]        waitSum;
   logic              timeout;

   always_comb begin
      memWait  = mem_req & ~mem_ready;
      loadUse  = ex_load & (ex_wreg != 5'd0) &
                 ((ex_wreg == id_rs) | (id_uses_rt & (ex_wreg == id_rt)));
      draining = (stateQ == StDrain) || ((stateQ == StMemWait) && haltFlagQ);
      // The first wait cycle is spent in RUN/DRAIN, so it counts toward the timeout.
      waitSum  = ((stateQ == StMemWait) ? waitCntQ : 9'd0) + 9'd1;
      timeout  = waitSum >= 9'(MEM_TIMEOUT);

      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_bubble = 1'b0;
      exmm_en     = 1'b1;
      mmwb_bubble = 1'b0;
      stallInc    = 1'b0;
      flushInc    = 1'b0;

      unique case (stateQ)
         StRun, StDrain, StMemWait: begin
            if (memWait) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmm_en     = 1'b0;
               mmwb_bubble = 1'b1;
               stallInc    = 1'b1;
            end else if (loadUse) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
               stallInc    = 1'b1;
            end else begin
               if (id_redirect) begin
                  ifid_flush = 1'b1;
                  flushInc   = 1'b1;
               end
               if (draining) begin
                  pc_en      = 1'b0;
                  ifid_flush = 1'b1;
               end
            end
         end
         StHalted: begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            mmwb_bubble = 1'b1;
         end
         default: begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmm_en     = 1'b0;
            mmwb_bubble = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ    <= StRun;
         waitCntQ  <= '0;
         drainCntQ <= '0;
         haltFlagQ <= 1'b0;
         errQ      <= 1'b0;
         haltedQ   <= 1'b0;
      end else begin
         unique case (stateQ)
            StRun, StDrain, StMemWait: begin
               if (memWait) begin
                  waitCntQ <= waitSum;
                  if (stateQ != StMemWait) haltFlagQ <= (stateQ == StDrain);
                  if (timeout) begin
                     stateQ <= StError;
                     errQ   <= 1'b1;
                  end else begin
                     stateQ <= StMemWait;
                  end
               end else if (stateQ == StMemWait) begin
                  waitCntQ <= '0;
                  stateQ   <= haltFlagQ ? StDrain : StRun;
               end else if (stateQ == StRun) begin
                  if (halt_req) begin
                     stateQ    <= StDrain;
                     drainCntQ <= DrainW'(DRAIN_CYCLES);
                  end
               end else if (!loadUse) begin
                  if (drainCntQ <= DrainW'(1)) begin
                     stateQ  <= StHalted;
                     haltedQ <= 1'b1;
                  end else begin
                     drainCntQ <= drainCntQ - DrainW'(1);
                  end
               end
            end
            StHalted: begin
               if (!halt_req) begin
                  stateQ  <= StRun;
                  haltedQ <= 1'b0;
               end
            end
            StError: ;
            default: begin
               stateQ <= StError;
               errQ   <= 1'b1;
            end
         endcase
      end
   end

   assign halted = haltedQ;
   assign err    = errQ;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (stallInc),
      .count (stall_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (flushInc),
      .count (flush_cnt)
   );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MM, WB). It generates the per-stage register enables and bubble/flush controls for the PC, IF/ID, ID/EX, EX/MM and MM/WB registers. It covers three hazard sources:
- load-use hazards, which operand forwarding cannot cover;
- control redirects (jump or taken branch resolved in ID);
- a variable-latency data-memory handshake.
It also provides halt/drain sequencing, a memory-timeout error and saturating stall/flush event counters.

Parameters:
CNT_W, 16, width of the stall and flush event counters (saturating)
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before err is raised (range 1..255)
DRAIN_CYCLES, 3, fetch-blocked cycles needed to retire in-flight ID/EX/MM instructions before halted

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  instruction in ID reads rt as a source
ex_load  in  1  instruction in EX is a load
ex_wreg  in  5  destination register of the instruction in EX
id_redirect  in  1  jump or taken branch resolved in ID this cycle
mem_req  in  1  instruction in MM performs a load or store
mem_ready  in  1  data memory completes the MM access this cycle
halt_req  in  1  level request to halt fetch and drain
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads a NOP
idex_en  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX loads a NOP (all control bits 0)
exmm_en  out  1  EX/MM load enable
mmwb_bubble  out  1  MM/WB loads a NOP (write-back disabled)
halted  out  1  pipeline drained and stopped
err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  number of stall cycles (load-use plus MEM_WAIT)
flush_cnt  out  CNT_W  number of IF/ID flushes

Behaviour:
Reset and shared rules:
- While rst is high: state=RUN, wait/drain counters=0, err=0, halted=0, stall_cnt=0, flush_cnt=0.
- Stage controls are combinational from state and inputs, so they respond in the same cycle as the condition (zero latency).
- Reset asserted mid-stall or mid-drain returns the block to RUN on the next edge.
- Default controls in RUN with no hazard: all enables=1, all flush/bubble=0.

Hazard terms:
- memwait = mem_req & ~mem_ready.
- loaduse = ex_load & (ex_wreg!=0) & ((ex_wreg==id_rs) | (id_uses_rt & (ex_wreg==id_rt))).
- Register $0 never creates a hazard.

Priority in RUN and DRAIN (highest first):
1. memwait:
   - pc_en, ifid_en, idex_en, exmm_en all 0 (whole front of the pipe is frozen).
   - mmwb_bubble=1.
   - Go to MEM_WAIT. stall_cnt +1.
2. loaduse:
   - pc_en=0, ifid_en=0, idex_bubble=1, exmm_en=1.
   - id_redirect is ignored this cycle; it is re-evaluated after the stall.
   - stall_cnt +1. Lasts exactly 1 cycle per hazard.
3. id_redirect:
   - ifid_flush=1, pc_en=1.
   - flush_cnt +1.

MEM_WAIT:
- Same freeze as memwait. stall_cnt +1 per cycle.
- Wait counter increments each cycle.
- On mem_ready=1: that cycle uses RUN controls and mmwb_bubble=0, and the state returns to RUN (or to DRAIN if the halt flag was latched).
- If the wait counter reaches MEM_TIMEOUT: err=1 and go to ERROR.

ERROR:
- All enables=0, mmwb_bubble=1. Exit only via rst.

Halt:
- halt_req sampled in RUN while no memwait is active: go to DRAIN and load the drain counter with DRAIN_CYCLES.
- DRAIN: pc_en=0, ifid_flush=1; all other stages run normally. Hazard rules 1–2 still apply.
- The drain counter decrements only on non-stall cycles. At 0: go to HALTED.
- HALTED: halted=1, pc_en=0, ifid_en=0, idex_bubble=1, mmwb_bubble=1.
- halt_req=0 in HALTED: return to RUN on the next edge, with halted=0 that same cycle.
- halt_req dropped during DRAIN: drain completes anyway, then HALTED exits on the following cycle.

Counters:
- stall_cnt and flush_cnt saturate at 2^CNT_W−1 and never wrap.

Decomposition:
- Shared package: state encoding (RUN, MEM_WAIT, DRAIN, HALTED, ERROR) and a NOP instruction constant shared with the IF/ID flush path.
- One sub-module: sat_counter (parameter width W; inputs inc and clr) instantiated for both event counters.
- The hazard detect terms stay inline.

Test Plan:
- lw $5 in EX, add $6,$5,$2 in ID (id_rs=5) → 1 cycle of pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt=1; next cycle all enables=1.
- ex_load=1, ex_wreg=0, id_rs=0 → no stall; id_uses_rt=0 with ex_wreg==id_rt → no stall.
- id_redirect=1 with loaduse in the same cycle → stall only, ifid_flush=0. Next cycle id_redirect=1 → ifid_flush=1, flush_cnt=1.
- mem_req=1, mem_ready=0 for 4 cycles then 1 → exmm_en=0 and mmwb_bubble=1 for 4 cycles; stall_cnt=4; 5th cycle normal.
- MEM_TIMEOUT=8, mem_ready held 0 → err=1 after 8 wait cycles; remains 1 until rst; after rst err=0 and state RUN.
- halt_req=1 → 3 cycles of pc_en=0 and ifid_flush=1, then halted=1. Drop halt_req → halted=0 next cycle, pc_en=1. Counter saturation at CNT_W=4: 20 stalls → stall_cnt=15.
